pipelined_alu_unit: RTL and testbench

Parametrised, valid/ready-handshaked, multi-stage integer ALU for the sail-core execute stage. It captures operands with MEM/WB forwarding applied and evaluates the RV32I ALU and CSR operations plus branch compare. It delivers result, branch flag and a pass-through tag after a configurable pipeline depth. Back-pressure stalls the whole pipe and a flush squashes in-flight work.

---
 rtl/pipelined_alu_unit.sv | 135 +++++++++++++
 tb/tb_pipelined_alu_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_unit.sv
// Execute-stage integer ALU with RV32I/CSR ops, branch compare and operand forwarding.
// The result is computed at accept and then carried through STAGES registers that share one global stall.
module pipelined_alu_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [2:0]       br,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             mem_fwd_a,
    input  logic             mem_fwd_b,
    input  logic             wb_fwd_a,
    input  logic             wb_fwd_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_branch,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_fwd;
    logic [WIDTH-1:0] b_fwd;
    logic [SHW-1:0]   shamt;
    logic             lt_s;
    logic             lt_u;
    logic             eq;
    logic [WIDTH-1:0] alu_res;
    logic             br_res;

    logic             stall;
    logic             accept;
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             valid_d;
    logic [STAGES-1:0][WIDTH-1:0]  data_q;
    logic [STAGES-1:0]             branch_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;

    // MEM is the younger producer, so it wins over WB.
    assign a_fwd = mem_fwd_a ? mem_result : (wb_fwd_a ? wb_result : a);
    assign b_fwd = mem_fwd_b ? mem_result : (wb_fwd_b ? wb_result : b);

    assign shamt = b_fwd[SHW-1:0];
    assign lt_s  = $signed(a_fwd) < $signed(b_fwd);
    assign lt_u  = a_fwd < b_fwd;
    assign eq    = a_fwd == b_fwd;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (op)
            4'd0:    alu_res = a_fwd & b_fwd;
            4'd1:    alu_res = a_fwd | b_fwd;
            4'd2:    alu_res = a_fwd + b_fwd;
            4'd3:    alu_res = a_fwd + ~b_fwd + WIDTH'(1);
            4'd4:    alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'd5:    alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            4'd6:    alu_res = a_fwd >> shamt;
            4'd7:    alu_res = WIDTH'($signed(a_fwd) >>> shamt);
            4'd8:    alu_res = a_fwd << shamt;
            4'd9:    alu_res = a_fwd ^ b_fwd;
            4'd10:   alu_res = a_fwd;
            4'd11:   alu_res = a_fwd | b_fwd;
            4'd12:   alu_res = ~a_fwd & b_fwd;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_res = 1'b0;
        case (br)
            3'd1:    br_res = eq;
            3'd2:    br_res = !eq;
            3'd3:    br_res = lt_s;
            3'd4:    br_res = !lt_s;
            3'd5:    br_res = lt_u;
            3'd6:    br_res = !lt_u;
            default: br_res = 1'b0;
        endcase
    end

    assign stall    = valid_q[STAGES-1] && !out_ready;
    assign in_ready = !stall && !flush;
    assign accept   = in_valid && in_ready;

    // The stall is global: bubbles are never compressed, the whole pipe shifts or holds.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d = (valid_q << 1) | STAGES'(accept);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: payload registers carry no reset; the valid bits gate them and the outputs are masked below.
    always_ff @(posedge clk) begin
        if (!stall) begin
            data_q[0]   <= alu_res;
            branch_q[0] <= br_res;
            tag_q[0]    <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                data_q[i]   <= data_q[i-1];
                branch_q[i] <= branch_q[i-1];
                tag_q[i]    <= tag_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_data   = out_valid ? data_q[STAGES-1] : '0;
    assign out_branch = out_valid ? branch_q[STAGES-1] : 1'b0;
    assign out_tag    = out_valid ? tag_q[STAGES-1] : '0;

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Directed bench for pipelined_alu_unit: a 32-bit/2-stage and a 16-bit/4-stage instance share one stimulus.
// The single-op vectors come from a table; back-to-back, back-pressure, flush and reset are written out cycle by cycle.
module tb_pipelined_alu_unit;

    localparam int S32 = 2;
    localparam int S16 = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [3:0]  op;
    logic [2:0]  br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mem_result;
    logic [31:0] wb_result;
    logic        mem_fwd_a;
    logic        mem_fwd_b;
    logic        wb_fwd_a;
    logic        wb_fwd_b;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_data32;
    logic        out_branch32;
    logic [4:0]  out_tag32;
    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] out_data16;
    logic        out_branch16;
    logic [4:0]  out_tag16;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_alu_unit #(.WIDTH(32), .STAGES(S32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .op(op), .br(br), .a(a), .b(b), .mem_result(mem_result), .wb_result(wb_result),
        .mem_fwd_a(mem_fwd_a), .mem_fwd_b(mem_fwd_b), .wb_fwd_a(wb_fwd_a), .wb_fwd_b(wb_fwd_b),
        .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_branch(out_branch32), .out_tag(out_tag32)
    );

    pipelined_alu_unit #(.WIDTH(16), .STAGES(S16), .TAG_W(5)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
        .op(op), .br(br), .a(a[15:0]), .b(b[15:0]), .mem_result(mem_result[15:0]), .wb_result(wb_result[15:0]),
        .mem_fwd_a(mem_fwd_a), .mem_fwd_b(mem_fwd_b), .wb_fwd_a(wb_fwd_a), .wb_fwd_b(wb_fwd_b),
        .in_tag(in_tag), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_branch(out_branch16), .out_tag(out_tag16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [2:0]  br;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fwd;    // {mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b}
        logic [31:0] mem;
        logic [31:0] wb;
        logic [31:0] exp32;
        logic        br32;
        logic [15:0] exp16;
        logic        br16;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [2:0] bc, input logic [31:0] va,
                         input logic [31:0] vb, input logic [4:0] t);
        op = o; br = bc; a = va; b = vb; in_tag = t;
        {mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b} = 4'b0000;
        in_valid = 1'b1;
    endtask

    task automatic clean();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int lat32, lat16;
        logic seen32, seen16;
        logic [31:0] d32;
        logic [15:0] d16;
        logic b32, b16;
        logic [4:0] t32, t16;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        op = v.op; br = v.br; a = v.a; b = v.b;
        {mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b} = v.fwd;
        mem_result = v.mem; wb_result = v.wb; in_tag = 5'(idx); in_valid = 1'b1;
        #1 check({v.name, "/in_ready"}, 64'({in_ready32, in_ready16}), 64'(2'b11));
        @(negedge clk);
        // Scramble everything: the op in flight must only reflect its accept cycle.
        in_valid = 1'b0;
        a = $urandom; b = $urandom; mem_result = $urandom; wb_result = $urandom;
        op = 4'($urandom); br = 3'($urandom); in_tag = 5'($urandom);
        {mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b} = 4'($urandom);
        cyc = 1; seen32 = 1'b0; seen16 = 1'b0; lat32 = 0; lat16 = 0;
        d32 = '0; d16 = '0; b32 = 1'b0; b16 = 1'b0; t32 = '0; t16 = '0;
        while (!(seen32 && seen16) && cyc <= 16) begin
            if (out_valid32 && !seen32) begin
                seen32 = 1'b1; lat32 = cyc; d32 = out_data32; b32 = out_branch32; t32 = out_tag32;
            end
            if (out_valid16 && !seen16) begin
                seen16 = 1'b1; lat16 = cyc; d16 = out_data16; b16 = out_branch16; t16 = out_tag16;
            end
            if (!(seen32 && seen16)) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({v.name, "/lat32"}, 64'(lat32), 64'(S32));
        check({v.name, "/data32"}, 64'(d32), 64'(v.exp32));
        check({v.name, "/br32"}, 64'(b32), 64'(v.br32));
        check({v.name, "/tag32"}, 64'(t32), 64'(idx));
        check({v.name, "/lat16"}, 64'(lat16), 64'(S16));
        check({v.name, "/data16"}, 64'(d16), 64'(v.exp16));
        check({v.name, "/br16"}, 64'(b16), 64'(v.br16));
        check({v.name, "/tag16"}, 64'(t16), 64'(idx));
    endtask

    task automatic run_b2b();
        logic [3:0]  bop[4] = '{4'd3, 4'd7, 4'd5, 4'd12};
        logic [31:0] ba[4]  = '{32'd5, 32'h8000_0000, 32'd1, 32'h0F};
        logic [31:0] bb[4]  = '{32'd7, 32'd31, 32'hFFFF_FFFF, 32'hFF};
        logic [31:0] e32[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hF0};
        logic [15:0] e16[4] = '{16'hFFFE, 16'h0000, 16'd1, 16'hF0};
        clean();
        for (int k = 0; k <= 4 + S16; k++) begin
            int j32 = k - S32;
            int j16 = k - S16;
            @(negedge clk);
            if (j32 >= 0 && j32 < 4) begin
                check($sformatf("b2b/v32_%0d", k), 64'(out_valid32), 64'(1));
                check($sformatf("b2b/d32_%0d", k), 64'(out_data32), 64'(e32[j32]));
                check($sformatf("b2b/t32_%0d", k), 64'(out_tag32), 64'(10 + j32));
            end else begin
                check($sformatf("b2b/idle32_%0d", k), 64'(out_valid32), 64'(0));
            end
            if (j16 >= 0 && j16 < 4) begin
                check($sformatf("b2b/v16_%0d", k), 64'(out_valid16), 64'(1));
                check($sformatf("b2b/d16_%0d", k), 64'(out_data16), 64'(e16[j16]));
            end else begin
                check($sformatf("b2b/idle16_%0d", k), 64'(out_valid16), 64'(0));
            end
            if (k < 4) drive(bop[k], 3'd0, ba[k], bb[k], 5'(10 + k));
            else in_valid = 1'b0;
        end
    endtask

    task automatic run_backpressure();
        clean();
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'd2, 3'd0, 32'd1, 32'd2, 5'd1);              // A: 3
        #1 check("bp/rdy_a", 64'(in_ready32), 64'(1));
        @(negedge clk);
        drive(4'd9, 3'd0, 32'hF0, 32'h0F, 5'd2);            // B: 0xFF
        #1 check("bp/rdy_b", 64'(in_ready32), 64'(1));
        @(negedge clk);
        drive(4'd3, 3'd0, 32'd10, 32'd3, 5'd3);             // C: 7
        #1 check("bp/rdy_full", 64'(in_ready32), 64'(0));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp/hold_v%0d", k), 64'(out_valid32), 64'(1));
            check($sformatf("bp/hold_d%0d", k), 64'(out_data32), 64'(3));
            check($sformatf("bp/hold_t%0d", k), 64'(out_tag32), 64'(1));
            check($sformatf("bp/hold_r%0d", k), 64'(in_ready32), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("bp/rel_a", 64'({out_valid32, out_data32}), {31'd0, 1'b1, 32'd3});
        #1 check("bp/rel_rdy", 64'(in_ready32), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/rel_b", 64'({out_valid32, out_tag32, out_data32}), {26'd0, 1'b1, 5'd2, 32'hFF});
        @(negedge clk);
        check("bp/rel_c", 64'({out_valid32, out_tag32, out_data32}), {26'd0, 1'b1, 5'd3, 32'd7});
        @(negedge clk);
        check("bp/drained", 64'(out_valid32), 64'(0));
    endtask

    task automatic run_flush();
        clean();
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'd2, 3'd0, 32'd1, 32'd1, 5'd4);
        @(negedge clk);
        drive(4'd2, 3'd0, 32'd2, 32'd2, 5'd5);
        @(negedge clk);
        check("flush/pre_valid", 64'(out_valid32), 64'(1));
        drive(4'd2, 3'd0, 32'd3, 32'd3, 5'd6);
        flush = 1'b1;
        #1 check("flush/rdy0", 64'(in_ready32), 64'(0));
        @(negedge clk);
        check("flush/cleared", 64'({out_valid32, out_branch32, out_tag32, out_data32}), 64'(0));
        flush = 1'b0;
        out_ready = 1'b1;
        #1 check("flush/rdy1", 64'(in_ready32), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("flush/no_ghost", 64'(out_valid32), 64'(0));
        @(negedge clk);
        check("flush/next_op", 64'({out_valid32, out_tag32, out_data32}), {26'd0, 1'b1, 5'd6, 32'd6});
        @(negedge clk);
        check("flush/empty", 64'(out_valid32), 64'(0));
    endtask

    task automatic run_async_reset();
        clean();
        @(negedge clk);
        drive(4'd2, 3'd1, 32'd2, 32'd2, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("arst/pre_valid", 64'(out_valid32), 64'(1));
        #2 rst = 1'b1;
        #1 check("arst/out32", 64'({out_valid32, out_branch32, out_tag32, out_data32}), 64'(0));
        check("arst/out16", 64'({out_valid16, out_branch16, out_tag16, out_data16}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("arst/rdy", 64'({in_ready32, in_ready16}), 64'(2'b11));
        @(negedge clk);
        check("arst/dropped", 64'({out_valid32, out_valid16}), 64'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; br = '0; a = '0; b = '0; mem_result = '0; wb_result = '0; in_tag = '0;
        {mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b} = 4'b0000;

        //          name          op     br     a              b              fwd      mem     wb      exp32          br32  exp16     br16
        vecs.push_back('{"add_ovf",  4'd2,  3'd0, 32'h7FFF_FFFF, 32'd1,         4'b0000, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"sub",      4'd3,  3'd1, 32'd5,         32'd7,         4'b0000, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 16'hFFFE, 1'b0});
        vecs.push_back('{"sra",      4'd7,  3'd0, 32'h8000_0000, 32'd31,        4'b0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"sltu",     4'd5,  3'd5, 32'd1,         32'hFFFF_FFFF, 4'b0000, 32'd0, 32'd0, 32'd1,         1'b1, 16'h0001, 1'b1});
        vecs.push_back('{"csrrc",    4'd12, 3'd2, 32'h0F,        32'hFF,        4'b0000, 32'd0, 32'd0, 32'hF0,        1'b1, 16'h00F0, 1'b1});
        vecs.push_back('{"and",      4'd0,  3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'd0, 32'd0, 32'hF000_F000, 1'b0, 16'hF000, 1'b0});
        vecs.push_back('{"or",       4'd1,  3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'd0, 32'd0, 32'hFFF0_FFF0, 1'b0, 16'hFFF0, 1'b0});
        vecs.push_back('{"slt",      4'd4,  3'd3, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0, 32'd0, 32'd1,         1'b1, 16'h0001, 1'b1});
        vecs.push_back('{"srl",      4'd6,  3'd5, 32'h8000_0000, 32'd33,        4'b0000, 32'd0, 32'd0, 32'h4000_0000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"sll",      4'd8,  3'd6, 32'd1,         32'd4,         4'b0000, 32'd0, 32'd0, 32'h10,        1'b0, 16'h0010, 1'b0});
        vecs.push_back('{"sll_max",  4'd8,  3'd0, 32'd1,         32'h1F,        4'b0000, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 16'h8000, 1'b0});
        vecs.push_back('{"xor",      4'd9,  3'd2, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'b0000, 32'd0, 32'd0, 32'h5A5A_5A5A, 1'b1, 16'h5A5A, 1'b1});
        vecs.push_back('{"pass",     4'd10, 3'd1, 32'h1234_5678, 32'd5,         4'b0000, 32'd0, 32'd0, 32'h1234_5678, 1'b0, 16'h5678, 1'b0});
        vecs.push_back('{"csrrs",    4'd11, 3'd4, 32'hF0,        32'h0F,        4'b0000, 32'd0, 32'd0, 32'hFF,        1'b1, 16'h00FF, 1'b1});
        vecs.push_back('{"op13",     4'd13, 3'd1, 32'd3,         32'd3,         4'b0000, 32'd0, 32'd0, 32'd0,         1'b1, 16'h0000, 1'b1});
        vecs.push_back('{"op15_br7", 4'd15, 3'd7, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0, 32'd0, 32'd0,         1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"bltu",     4'd2,  3'd5, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0, 32'd0, 32'd0,         1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"bgeu_eq",  4'd4,  3'd6, 32'd5,         32'd5,         4'b0000, 32'd0, 32'd0, 32'd0,         1'b1, 16'h0000, 1'b1});
        vecs.push_back('{"blt",      4'd3,  3'd3, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, 16'hFFFE, 1'b1});
        vecs.push_back('{"fwd_mem",  4'd2,  3'd1, 32'd1,         32'd1,         4'b1010, 32'd9, 32'd4, 32'd10,        1'b0, 16'd10,   1'b0});
        vecs.push_back('{"fwd_wb",   4'd2,  3'd1, 32'd1,         32'd1,         4'b0010, 32'd9, 32'd4, 32'd5,         1'b0, 16'd5,    1'b0});
        vecs.push_back('{"fwd_b_mem",4'd3,  3'd3, 32'h14,        32'd0,         4'b0101, 32'd9, 32'd4, 32'h0B,        1'b0, 16'h000B, 1'b0});
        vecs.push_back('{"fwd_b_wb", 4'd3,  3'd1, 32'h14,        32'd0,         4'b0001, 32'd9, 32'd4, 32'h10,        1'b0, 16'h0010, 1'b0});
        vecs.push_back('{"sra_16",   4'd7,  3'd0, 32'hFFFF_8000, 32'd15,        4'b0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b0});

        #1;
        check("reset/out32", 64'({out_valid32, out_branch32, out_tag32, out_data32}), 64'(0));
        check("reset/out16", 64'({out_valid16, out_branch16, out_tag16, out_data16}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset/in_ready", 64'({in_ready32, in_ready16}), 64'(2'b11));
        check("reset/out_valid", 64'({out_valid32, out_valid16}), 64'(0));

        foreach (vecs[i]) run_vec(vecs[i], i);
        run_b2b();
        run_backpressure();
        run_flush();
        run_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
